// File: rtl/mips_dmem_responder_if.sv
// Load/store bus between the MipsCPU core (master) and the data-memory
// responder (slave). Request fields are driven by the initiator and the
// completion fields by the responder.
interface mips_dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MipsCPU load/store port.
// Accepts a word request in IDLE, spends WAIT_CYCLES cycles in WAIT, then
// spends one RESP cycle with ack high. The memory write, the error decision
// and the read-data capture all happen on the edge that enters RESP, so all
// outputs are registered. The memory array has no reset and keeps its
// contents across rst_init.
module mips_dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk_init,
  input  logic                 rst_init,
  mips_dmem_responder_if.slave bus
);

  localparam int NUM_WORDS = 1 << DEPTH_LOG2;

  // Counter preload when leaving IDLE. With zero wait states the WAIT state
  // is skipped, so this value is never used in that case.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  logic [31:0] mem [NUM_WORDS];

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic        accept;
  logic        enter_resp;

  logic        lat_we_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [3:0]  lat_be_q;

  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        cmd_err;
  logic [DEPTH_LOG2-1:0] cmd_idx;
  logic        mem_wr;

  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;

  // Pick the command to act on: the live bus while IDLE (only matters when
  // zero wait states go straight to RESP), otherwise the latched copy so bus
  // changes during WAIT are ignored.
  always_comb begin
    cmd_we    = lat_we_q;
    cmd_addr  = lat_addr_q;
    cmd_wdata = lat_wdata_q;
    cmd_be    = lat_be_q;
    if (state_q == ST_IDLE) begin
      cmd_we    = bus.we;
      cmd_addr  = bus.addr;
      cmd_wdata = bus.wdata;
      cmd_be    = bus.be;
    end
  end

  // Misaligned addresses and word indices beyond the array are errors.
  // The range test assumes DEPTH_LOG2 <= 29.
  assign cmd_idx = cmd_addr[DEPTH_LOG2+1:2];
  assign cmd_err = (cmd_addr[1:0] != 2'b00) || (cmd_addr[31:DEPTH_LOG2+2] != '0);

  // Writes commit only on the RESP-entry edge of a good request, and never
  // while reset is held (the IDLE zero-wait path would otherwise see req).
  assign mem_wr = enter_resp & cmd_we & ~cmd_err & rst_init;

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk_init or negedge rst_init) begin
    if (!rst_init) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Capture the request fields at acceptance.
  always_ff @(posedge clk_init or negedge rst_init) begin
    if (!rst_init) begin
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_be_q    <= 4'd0;
    end else if (accept) begin
      lat_we_q    <= bus.we;
      lat_addr_q  <= bus.addr;
      lat_wdata_q <= bus.wdata;
      lat_be_q    <= bus.be;
    end
  end

  // Registered completion outputs: valid for exactly the RESP cycle, busy
  // for every non-IDLE cycle. Read data is the pre-write word.
  always_ff @(posedge clk_init or negedge rst_init) begin
    if (!rst_init) begin
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q   <= enter_resp;
      err_q   <= enter_resp & cmd_err;
      rdata_q <= (enter_resp && !cmd_we && !cmd_err) ? mem[cmd_idx] : 32'd0;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Byte-masked memory write; the array itself is never reset.
  always_ff @(posedge clk_init) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (cmd_be[i]) begin
          mem[cmd_idx][8*i +: 8] <= cmd_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: one instance with two wait states and one
// with zero wait states, driven one at a time from a shared initiator and
// checked against a word-array model of the memory and bus rules.
module tb_mips_dmem_responder;

  localparam int DEPTH_LOG2 = 8;
  localparam int NWORDS     = 1 << DEPTH_LOG2;
  localparam int WAIT_A     = 2;
  localparam int WAIT_B     = 0;

  logic        clk_init = 1'b1;
  logic        rst_init = 1'b0;
  logic        req      = 1'b0;
  logic        we       = 1'b0;
  logic [31:0] addr     = 32'd0;
  logic [31:0] wdata    = 32'd0;
  logic [3:0]  be       = 4'd0;
  logic        sel      = 1'b0;
  logic        held     = 1'b0;
  logic [31:0] last_rd  = 32'd0;

  logic        ack_s;
  logic        err_s;
  logic        busy_s;
  logic [31:0] rdata_s;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mem_m [2][NWORDS];

  mips_dmem_responder_if bus_a ();
  mips_dmem_responder_if bus_b ();

  mips_dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk_init (clk_init),
    .rst_init (rst_init),
    .bus      (bus_a)
  );

  mips_dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_B)) u_dut_b (
    .clk_init (clk_init),
    .rst_init (rst_init),
    .bus      (bus_b)
  );

  assign bus_a.req   = req & ~sel;
  assign bus_a.we    = we;
  assign bus_a.addr  = addr;
  assign bus_a.wdata = wdata;
  assign bus_a.be    = be;
  assign bus_b.req   = req & sel;
  assign bus_b.we    = we;
  assign bus_b.addr  = addr;
  assign bus_b.wdata = wdata;
  assign bus_b.be    = be;

  assign ack_s   = sel ? bus_b.ack   : bus_a.ack;
  assign err_s   = sel ? bus_b.err   : bus_a.err;
  assign busy_s  = sel ? bus_b.busy  : bus_a.busy;
  assign rdata_s = sel ? bus_b.rdata : bus_a.rdata;

  always #5 clk_init = ~clk_init;

  // Single comparison point for every check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (dut %s, t=%0t)", tag, got, exp, sel ? "w0" : "w2", $time);
    end
  endtask

  function automatic logic modelErr(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= NWORDS);
  endfunction

  // Wait for ack from a negedge; while waiting past acceptance, scramble the
  // bus fields to show the latched copy is used.
  task automatic waitAck(input int pre, output int cyc, output logic got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk_init);
      cyc++;
      @(negedge clk_init);
      if (ack_s) begin
        got = 1'b1;
      end else if (cyc > pre) begin
        checkOutput("busy_wait", 32'(busy_s), 32'd1);
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        be    = 4'($urandom);
      end
    end
  endtask

  // Issue one transaction from a negedge and check it against the model.
  task automatic applyStimulus(input logic t_we, input logic [31:0] t_addr,
                               input logic [31:0] t_wdata, input logic [3:0] t_be,
                               input logic keep_req);
    int          w;
    int          pre;
    int          cyc;
    int          idx;
    logic        got;
    logic        exp_err;
    logic [31:0] exp_rd;
    w   = sel ? WAIT_B : WAIT_A;
    pre = held ? 1 : 0;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    be    = t_be;
    req   = 1'b1;
    exp_err = modelErr(t_addr);
    idx     = exp_err ? 0 : int'(t_addr / 4);
    exp_rd  = (!exp_err && !t_we) ? mem_m[int'(sel)][idx] : 32'd0;
    if (!exp_err && t_we) begin
      for (int i = 0; i < 4; i++) begin
        if (t_be[i]) mem_m[int'(sel)][idx][8*i +: 8] = t_wdata[8*i +: 8];
      end
    end
    waitAck(pre, cyc, got);
    checkOutput("ack_seen", 32'(got), 32'd1);
    if (got) begin
      checkOutput("latency", 32'(cyc), 32'(w + 1 + pre));
      checkOutput("rdata", rdata_s, exp_rd);
      checkOutput("err", 32'(err_s), 32'(exp_err));
      checkOutput("busy_resp", 32'(busy_s), 32'd1);
      last_rd = rdata_s;
    end
    held = keep_req;
    if (!keep_req) begin
      req = 1'b0;
      @(negedge clk_init);
      checkOutput("after_ack_flags", 32'({ack_s, err_s, busy_s}), 32'd0);
      checkOutput("after_ack_rdata", rdata_s, 32'd0);
    end
  endtask

  function automatic logic [31:0] randAddr();
    int          r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r == 0)      a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
    else if (r == 1) a = {22'($urandom_range(1, 4194303)), 8'($urandom), 2'b00};
    else if (r < 6)  a = {26'd0, 4'($urandom), 2'b00};
    else             a = {22'd0, 8'($urandom), 2'b00};
    return a;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle behaviour on both instances.
    #50;
    checkOutput("rst_flags_a", 32'({bus_a.ack, bus_a.err, bus_a.busy}), 32'd0);
    checkOutput("rst_flags_b", 32'({bus_b.ack, bus_b.err, bus_b.busy}), 32'd0);
    #45;
    rst_init = 1'b1;
    repeat (20) begin
      @(negedge clk_init);
      checkOutput("idle_flags", 32'({bus_a.ack, bus_a.err, bus_a.busy, bus_b.ack, bus_b.err, bus_b.busy}), 32'd0);
      checkOutput("idle_rdata", bus_a.rdata | bus_b.rdata, 32'd0);
    end

    // Prefill both memories with zeros, back-to-back.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < NWORDS; i++) begin
        applyStimulus(1'b1, 32'(i * 4), 32'd0, 4'hF, i < NWORDS - 1);
      end
    end

    // Directed cases on the two-wait-state instance.
    sel = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    checkOutput("wr_rd_const", last_rd, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h3, 1'b0);
    checkOutput("be_merge_const", last_rd, 32'h11BB33DD);
    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    applyStimulus(1'b0, 32'h22, 32'h0, 4'hF, 1'b0);
    applyStimulus(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);

    // Reset pulse during WAIT aborts the write.
    we    = 1'b1;
    addr  = 32'h30;
    wdata = 32'h55AA55AA;
    be    = 4'hF;
    req   = 1'b1;
    @(posedge clk_init);
    @(negedge clk_init);
    rst_init = 1'b0;
    #2;
    checkOutput("midwait_rst_flags", 32'({ack_s, err_s, busy_s}), 32'd0);
    req = 1'b0;
    @(negedge clk_init);
    rst_init = 1'b1;
    repeat (4) begin
      @(negedge clk_init);
      checkOutput("midwait_no_ack", 32'({ack_s, busy_s}), 32'd0);
    end
    applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
    checkOutput("midwait_old_value", last_rd, 32'h00000000);

    // Zero-wait instance: held req, three writes then read-back.
    sel = 1'b1;
    applyStimulus(1'b1, 32'h0, 32'h01010101, 4'hF, 1'b1);
    applyStimulus(1'b1, 32'h4, 32'h02020202, 4'hF, 1'b1);
    applyStimulus(1'b1, 32'h8, 32'h03030303, 4'hF, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, 1'b1);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
    checkOutput("b2b_last_word", last_rd, 32'h03030303);

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int n = 0; n < 120; n++) begin
        logic keep;
        keep = (n < 119) && ($urandom_range(0, 2) == 0);
        applyStimulus(1'($urandom), randAddr(), $urandom, 4'($urandom), keep);
        if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk_init);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
